if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
//  Owns the PC and drives imem_addr. Captures imem_inst one cycle later. Presents
//  {pc, inst} to decode through a registered valid/ready output slot plus a 1-entry
//  skid buffer. Handles decode stalls and branch/jump redirects.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC issued first after reset release
//  NOP_INST   32'h0000_0013  value on if_inst when slot empty/flushed (addi x0,x0,0)
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous reset, active-low
//  imem_addr       out  32  byte address to instruction memory; read registered, data next cycle
//  imem_inst       in   32  instruction for address presented previous cycle
//  redirect_valid  in   1   one-cycle pulse: branch/jump taken, flush fetch
//  redirect_pc     in   32  target PC, sampled when redirect_valid=1
//  id_ready        in   1   decode accepts slot this cycle
//  if_valid        out  1   if_pc/if_inst hold a valid instruction
//  if_pc           out  32  PC of presented instruction
//  if_inst         out  32  presented instruction
//  if_misalign     out  1   presented entry is a misaligned-fetch exception (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): pc_q=RESET_PC, resp_vld=0, skid_vld=0, if_valid=0, if_pc=0,
//    if_inst=NOP_INST, if_misalign=0. First imem_addr after release = RESET_PC.
//  - imem_addr = redirect_valid ? redirect_pc : pc_q (combinational bypass).
//  - issue_en = !skid_vld && !(resp_vld && if_valid && !id_ready).
//    * On issue: pc_q <= imem_addr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//    * On issue: resp_vld <= 1, resp_pc <= imem_addr. Otherwise resp_vld <= 0 and pc_q holds.
//  - Response cycle (resp_vld=1): {resp_pc, imem_inst} is valid this cycle only (memory has no enable).
//    * If slot empty, or slot accepted (if_valid && id_ready), and skid empty: response -> output slot.
//    * Else: response -> skid buffer.
//  - Slot drain: when if_valid && id_ready, slot loads skid if skid_vld (skid_vld<=0).
//    * Else slot loads the direct response if resp_vld; else if_valid<=0 and if_inst<=NOP_INST.
//  - Program order always kept: skid entry precedes any newer response.
//  - Latency: issue at cycle N -> imem data N+1 -> if_valid at N+2. Throughput 1 instr/cycle while id_ready=1.
//  - Stall: if_pc/if_inst/if_valid hold stable while if_valid && !id_ready. Skid absorbs at most one in-flight response; no loss, no duplication.
//  - Redirect (highest priority, same cycle):
//    * if_valid, skid_vld and the in-flight resp are discarded (next-cycle if_valid=0); slot not handed over even if id_ready=1.
//    * redirect_pc is issued this cycle regardless of skid/stall state; pc_q <= redirect_pc+4.
//    * First target instruction reaches if_valid 2 cycles later.
//  - Redirect on first cycle after reset is legal and overrides RESET_PC.
//  - Reset mid-operation: all state returns to reset values immediately; no partial output.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined:
//    * redirect_pc[1:0]!=0 -> no memory issue. 2 cycles later slot presents if_valid=1, if_misalign=1, if_pc=redirect_pc, if_inst=NOP_INST.
//    * Fetch then halts (no issue) until next redirect_valid.
//  FETCH_MISALIGN_CHK_EN undefined:
//    * redirect_pc[1:0] forced to 2'b00 before use. if_misalign tied 0.
// TESTING
//  1 reset, id_ready=1: imem_addr 0,4,8,... each cycle; if_valid rises 2 cycles after release,
//    if_pc 0,4,8 consecutive, if_inst matches preloaded words.
//  2 id_ready=0 for 3 cycles mid-stream: if_pc held at 0x8, no instruction lost/duplicated;
//    after release sequence continues 0xC,0x10 back-to-back.
//  3 redirect_valid with redirect_pc=0x100 while stalled and skid full: next cycle if_valid=0;
//    2 cycles later if_pc=0x100, then 0x104; old 0xC never appears.
//  4 redirect at reset release to 0x40: imem_addr=0x40 that cycle, first if_pc=0x40.
//  5 with FETCH_MISALIGN_CHK_EN, redirect_pc=0x102: if_misalign=1, if_pc=0x102, imem_addr
//    frozen until redirect to 0x200 resumes fetch. Without macro: if_pc=0x100.
//  6 PC wrap: redirect to 0xFFFF_FFFC -> if_pc 0xFFFF_FFFC followed by 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem_addr, and presents {pc, inst} to decode through an output slot backed by a 1-entry skid buffer.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect targets raise a fetch exception instead of being force-aligned.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_misalign
);

  logic [31:0] r_pc;
  logic        r_halt;
  logic        r_resp_vld;
  logic [31:0] r_resp_pc;
  logic        r_resp_mis;
  logic        r_skid_vld;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_skid_mis;

  logic [31:0] w_redir_pc;
  logic        w_mis_redir;
  logic        w_accept;
  logic        w_issue;
  logic [31:0] w_resp_inst;
  logic [31:0] w_pc_next;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_redir_pc  = redirect_pc;
  assign w_mis_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
  assign w_mis_redir = 1'b0;
`endif

  assign imem_addr   = redirect_valid ? w_redir_pc : r_pc;
  assign w_accept    = if_valid && id_ready;
  assign w_issue     = redirect_valid ? !w_mis_redir
                                      : (!r_halt && !r_skid_vld &&
                                         !(r_resp_vld && if_valid && !id_ready));
  // A misaligned pseudo-response carries no memory data; it presents a NOP.
  assign w_resp_inst = r_resp_mis ? NOP_INST : imem_inst;
  assign w_pc_next   = imem_addr + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_halt      <= 1'b0;
      r_resp_vld  <= 1'b0;
      r_resp_pc   <= '0;
      r_resp_mis  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
      r_skid_mis  <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_inst     <= NOP_INST;
      if_misalign <= 1'b0;
    end else if (redirect_valid) begin
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_misalign <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_resp_vld  <= 1'b1;
      r_resp_pc   <= w_redir_pc;
      r_resp_mis  <= w_mis_redir;
      r_halt      <= w_mis_redir;
      r_pc        <= w_issue ? w_pc_next : w_redir_pc;
    end else begin
      if (w_issue) begin
        r_pc <= w_pc_next;
      end
      r_resp_vld <= w_issue;
      r_resp_pc  <= imem_addr;
      r_resp_mis <= 1'b0;

      // Skid always drains ahead of a newer response to keep program order.
      if (w_accept && r_skid_vld) begin
        if_valid    <= 1'b1;
        if_pc       <= r_skid_pc;
        if_inst     <= r_skid_inst;
        if_misalign <= r_skid_mis;
        r_skid_vld  <= r_resp_vld;
        if (r_resp_vld) begin
          r_skid_pc   <= r_resp_pc;
          r_skid_inst <= w_resp_inst;
          r_skid_mis  <= r_resp_mis;
        end
      end else if (!if_valid || w_accept) begin
        if (r_resp_vld) begin
          if_valid    <= 1'b1;
          if_pc       <= r_resp_pc;
          if_inst     <= w_resp_inst;
          if_misalign <= r_resp_mis;
        end else begin
          if_valid    <= 1'b0;
          if_inst     <= NOP_INST;
          if_misalign <= 1'b0;
        end
      end else if (r_resp_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_pc   <= r_resp_pc;
        r_skid_inst <= w_resp_inst;
        r_skid_mis  <= r_resp_mis;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: directed streams, stalls, redirects, PC wrap, misaligned redirect and reset.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_misalign(if_misalign)
  );

  function automatic logic [31:0] minst(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Memory read is registered: data for the address presented this cycle appears next cycle.
  always @(posedge clk) imem_inst <= minst(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] pc);
    exp_q.push_back({pc, minst(pc), 1'b0});
  endtask

  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got pc 0x%08h expected none", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_pc", if_pc, e.pc);
        chk("acc_inst", if_inst, e.inst);
        chk("acc_mis", {31'b0, if_misalign}, {31'b0, e.mis});
      end
    end
  end

  task automatic wait_pc(input logic [31:0] t);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk); #1;
      hit = if_valid && (if_pc == t);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pc: got pc 0x%08h expected 0x%08h within 40 cycles", if_pc, t);
    end
  endtask

  task automatic stop_after;
    @(posedge clk); #1;
    id_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_mis", {31'b0, if_misalign}, 32'd0);

    // Sequential stream, then stall at 0x8 and at 0x18
    for (int unsigned a = 0; a <= 32'h14; a += 4) push_seq(a);
    rst_n = 1'b1;
    #1 chk("first_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("addr_4", imem_addr, 32'h4);
    chk("lat_valid0", {31'b0, if_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid1", {31'b0, if_valid}, 32'd1);
    chk("lat_pc", if_pc, 32'h0);
    chk("addr_8", imem_addr, 32'h8);
    wait_pc(32'h8);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
    end
    id_ready = 1'b1;
    wait_pc(32'h18);
    id_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Redirect while stalled with skid full
    push_seq(32'h100); push_seq(32'h104); push_seq(32'h108);
    redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
    #1 chk("redir_addr", imem_addr, 32'h100);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("redir_flush", {31'b0, if_valid}, 32'd0);
    @(posedge clk); #1;
    chk("redir_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_pc", if_pc, 32'h100);
    wait_pc(32'h108);
    stop_after();

    // PC wrap
    push_seq(32'hFFFF_FFFC); push_seq(32'h0); push_seq(32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; id_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pc(32'h4);
    stop_after();

    // Misaligned redirect
`ifdef FETCH_MISALIGN_CHK_EN
    exp_q.push_back({32'h102, NOP, 1'b1});
    redirect_valid = 1'b1; redirect_pc = 32'h102; id_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pc(32'h102);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("halt_addr", imem_addr, 32'h102);
      chk("halt_valid", {31'b0, if_valid}, 32'd0);
    end
    push_seq(32'h200); push_seq(32'h204);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pc(32'h204);
    stop_after();
`else
    push_seq(32'h100); push_seq(32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h102; id_ready = 1'b1;
    #1 chk("align_addr", imem_addr, 32'h100);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pc(32'h104);
    stop_after();
`endif

    // Reset mid-operation, then redirect on the first cycle after release
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_inst", if_inst, NOP);
    chk("mid_rst_pc", if_pc, 32'h0);
    push_seq(32'h40); push_seq(32'h44);
    @(posedge clk); #1;
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    #1 chk("rel_redir_addr", imem_addr, 32'h40);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_pc(32'h44);
    stop_after();

    repeat (5) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
